// File: rtl/noc_axi_pkg.sv
// Shared types and constants for the NoC-to-AXI request sequencer.
package noc_axi_pkg;

    localparam logic [1:0] MSG_TYPE_INVAL = 2'd0;
    localparam logic [1:0] MSG_TYPE_LOAD  = 2'd1;
    localparam logic [1:0] MSG_TYPE_STORE = 2'd2;

    // Bit positions inside the 6-bit flit-info word pushed to the type FIFO
    localparam int TW_FLIT_TYPE_LSB = 0;
    localparam int TW_FLIT_TYPE_MSB = 1;
    localparam int TW_WORD_SEL      = 2;
    localparam int TW_READ_SIZE     = 3;
    localparam int TW_LAST_READ     = 4;
    localparam int TW_LAST_WRITE    = 5;
    localparam int TW_WIDTH         = 6;

    typedef enum logic [1:0] {
        SEQ_IDLE     = 2'd0,
        SEQ_RD_BURST = 2'd1,
        SEQ_WR_BURST = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic       last_write_flit;
        logic       last_read_transfer;
        logic       read_size;
        logic       read_word_select;
        logic [1:0] flit_type;
    } flit_info_t;

    // Builds the type-FIFO word for the beat currently on the request bus.
    // Reads are always 8B (read_size=0); the word select is address bit 3.
    function automatic flit_info_t make_flit_info(input logic issuing,
                                                  input logic store,
                                                  input logic word_sel,
                                                  input logic last);
        logic [TW_WIDTH-1:0] w;
        w = '0;
        w[TW_FLIT_TYPE_MSB:TW_FLIT_TYPE_LSB] = !issuing ? MSG_TYPE_INVAL :
                                               (store ? MSG_TYPE_STORE : MSG_TYPE_LOAD);
        w[TW_WORD_SEL]   = word_sel;
        w[TW_READ_SIZE]  = 1'b0;
        w[TW_LAST_READ]  = !store && last;
        w[TW_LAST_WRITE] = store && last;
        return flit_info_t'(w);
    endfunction

endpackage

// File: rtl/noc_axi_rr_arb2.sv
// Two-way round-robin arbiter between read and write burst commands.
// Grants are combinational; since a grant requires the request, a grant
// is also the acceptance, so rr_last updates on every grant.
module noc_axi_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_rd,
    input  logic req_wr,
    output logic gnt_rd,
    output logic gnt_wr
);

    logic last_wr_q;

    // Grant the sole requester, or the one not served last when both request
    always_comb begin
        gnt_rd = en && req_rd && (!req_wr || last_wr_q);
        gnt_wr = en && req_wr && (!req_rd || !last_wr_q);
    end

    // Remember the last granted side; reset favours read first
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_wr_q <= 1'b1;
        end else if (gnt_rd) begin
            last_wr_q <= 1'b0;
        end else if (gnt_wr) begin
            last_wr_q <= 1'b1;
        end
    end

endmodule

// File: rtl/noc_axi_txn_sequencer.sv
// Splits AXI read/write bursts into 8-byte NoC requests, pushes one
// flit-info word per issued beat and throttles on outstanding requests.
//
// state        | meaning
// SEQ_IDLE     | waiting for a command; arbiter grants are live
// SEQ_RD_BURST | issuing load beats for the accepted read burst
// SEQ_WR_BURST | issuing store beats, each gated on buffered write data
module noc_axi_txn_sequencer
    import noc_axi_pkg::*;
#(
    parameter int ADDR_WIDTH      = 40,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_WIDTH       = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_cmd_valid,
    output logic                  rd_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_cmd_addr,
    input  logic [7:0]            rd_cmd_len,
    input  logic                  wr_cmd_valid,
    output logic                  wr_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] wr_cmd_addr,
    input  logic [7:0]            wr_cmd_len,
    input  logic                  wr_data_avail,
    output logic                  noc_req_valid,
    input  logic                  noc_req_ready,
    output logic [ADDR_WIDTH-1:0] noc_req_addr,
    output logic                  noc_req_store,
    output logic [5:0]            transaction_type_wr_data,
    output logic                  transaction_type_wr,
    input  logic                  L2_request_ack,
    output logic [CNT_WIDTH-1:0]  outstanding,
    output logic                  ack_underflow
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-3){1'b1}}, 3'b000};
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(8);
    localparam logic [CNT_WIDTH-1:0]  CNT_LIMIT  = CNT_WIDTH'(MAX_OUTSTANDING);

    seq_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            beats_left_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  underflow_q;
    logic                  arb_en, gnt_rd, gnt_wr;
    logic                  below_limit, last_beat, beat_fire;

    // Nothing handshakes while reset is asserted, so no command or beat is lost
    assign arb_en      = rst_n && (state_q == SEQ_IDLE);
    assign below_limit = cnt_q < CNT_LIMIT;
    assign last_beat   = (beats_left_q == 8'd0);

    noc_axi_rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (arb_en),
        .req_rd (rd_cmd_valid),
        .req_wr (wr_cmd_valid),
        .gnt_rd (gnt_rd),
        .gnt_wr (gnt_wr)
    );

    assign rd_cmd_ready = gnt_rd;
    assign wr_cmd_ready = gnt_wr;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, beat issue gating and handshake detection
    always_comb begin
        state_d       = state_q;
        noc_req_valid = 1'b0;
        beat_fire     = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (gnt_rd) begin
                    state_d = SEQ_RD_BURST;
                end else if (gnt_wr) begin
                    state_d = SEQ_WR_BURST;
                end
            end
            SEQ_RD_BURST: noc_req_valid = rst_n && below_limit;
            SEQ_WR_BURST: noc_req_valid = rst_n && below_limit && wr_data_avail;
            default:      state_d = SEQ_IDLE;
        endcase
        beat_fire = noc_req_valid && noc_req_ready;
        if (beat_fire && last_beat) begin
            state_d = SEQ_IDLE;
        end
    end

    assign noc_req_addr             = addr_q;
    assign noc_req_store            = (state_q == SEQ_WR_BURST);
    assign transaction_type_wr      = beat_fire;
    assign transaction_type_wr_data = make_flit_info(noc_req_valid, noc_req_store,
                                                     addr_q[3], last_beat);
    assign outstanding              = cnt_q;
    assign ack_underflow            = underflow_q;

    // Burst address/beat tracking and the outstanding-request counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q       <= '0;
            beats_left_q <= '0;
            cnt_q        <= '0;
            underflow_q  <= 1'b0;
        end else begin
            if (gnt_rd) begin
                addr_q       <= rd_cmd_addr & ALIGN_MASK;
                beats_left_q <= rd_cmd_len;
            end else if (gnt_wr) begin
                addr_q       <= wr_cmd_addr & ALIGN_MASK;
                beats_left_q <= wr_cmd_len;
            end else if (beat_fire) begin
                addr_q       <= addr_q + BEAT_BYTES;
                beats_left_q <= beats_left_q - 8'd1;
            end

            case ({beat_fire, L2_request_ack})
                2'b10: cnt_q <= cnt_q + CNT_WIDTH'(1);
                2'b01: begin
                    if (cnt_q == '0) begin
                        underflow_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                    end
                end
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule
